barrel_shift_pipe: RTL



---
 rtl/barrel_shift_pipe.sv | 104 ++++++++++
 1 files changed

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit, with a
// single global advance enable driving valid/ready flow control.
module barrel_shift_pipe #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [2:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero
);

    localparam logic [2:0] ModeSll = 3'b000;
    localparam logic [2:0] ModeSrl = 3'b001;
    localparam logic [2:0] ModeSra = 3'b010;
    localparam logic [2:0] ModeRol = 3'b011;
    localparam logic [2:0] ModeRor = 3'b100;

    function automatic logic [WIDTH-1:0] step_shift(input logic [WIDTH-1:0] d,
                                                    input logic [2:0]       m,
                                                    input logic             en,
                                                    input int unsigned      amt);
        step_shift = d;
        if (en) begin
            case (m)
                ModeSll: step_shift = d << amt;
                ModeSrl: step_shift = d >> amt;
                ModeSra: step_shift = $signed(d) >>> amt;
                ModeRol: step_shift = (d << amt) | (d >> (WIDTH - amt));
                ModeRor: step_shift = (d >> amt) | (d << (WIDTH - amt));
                default: step_shift = d;
            endcase
        end
    endfunction

    logic                              adv;
    logic [SHAMT_W-1:0]                vld_q, vld_d;
    logic [SHAMT_W-1:0][WIDTH-1:0]     data_q, data_d;
    logic [SHAMT_W-1:0][2:0]           mode_q, mode_d;
    // rem_q[k] holds the shift amount already shifted right by k+1: bit 0 feeds stage k+1.
    logic [SHAMT_W-1:0][SHAMT_W-1:0]   rem_q, rem_d;
    logic                              zero_q, zero_d;

    assign adv      = !out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        logic               src_vld;
        logic [WIDTH-1:0]   src_data;
        logic [2:0]         src_mode;
        logic [SHAMT_W-1:0] src_rem;

        if (k == 0) begin : g_first
            assign src_vld  = in_valid & adv;
            assign src_data = in_data;
            assign src_mode = in_mode;
            assign src_rem  = in_shamt;
        end else begin : g_next
            assign src_vld  = vld_q[k-1];
            assign src_data = data_q[k-1];
            assign src_mode = mode_q[k-1];
            assign src_rem  = rem_q[k-1];
        end

        assign vld_d[k]  = src_vld;
        assign data_d[k] = step_shift(src_data, src_mode, src_rem[0], 32'd1 << k);
        assign mode_d[k] = src_mode;
        assign rem_d[k]  = src_rem >> 1;
    end

    assign zero_d = (data_d[SHAMT_W-1] == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            data_q <= '0;
            mode_q <= '0;
            rem_q  <= '0;
            zero_q <= 1'b0;
        end else if (adv) begin
            vld_q  <= vld_d;
            data_q <= data_d;
            mode_q <= mode_d;
            rem_q  <= rem_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = vld_q[SHAMT_W-1];
    assign out_data  = data_q[SHAMT_W-1];
    assign out_zero  = zero_q;

    // The last stage's mode and remaining amount have no consumer.
    logic unused_tail;
    assign unused_tail = ^{mode_q[SHAMT_W-1], rem_q[SHAMT_W-1]};

endmodule
